// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the multi-cycle phase sequencer.
package cpu_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6,
      S_ERROR  = 3'd7
   } state_e;

   localparam logic [2:0] STACK_NONE = 3'b000;
   localparam logic [2:0] STACK_PUSH = 3'b001;
   localparam logic [2:0] STACK_CALL = 3'b010;
   localparam logic [2:0] STACK_RET  = 3'b011;
   localparam logic [2:0] STACK_POP  = 3'b100;

   localparam int unsigned MEM_TIMEOUT_DEFAULT = 15;

   // Counter must hold the timeout value itself on the expiring cycle.
   function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/cpu_sequencer_mem_wait_timer.sv
// Consecutive not-ready watchdog shared by the FETCH and MEM waits.
module mem_wait_timer #(
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned CNT_W   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic en_i,
   input  logic ready_i,
   output logic expired_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Expires on the cycle the count would reach TIMEOUT; a ready in that cycle wins.
   assign expired_o = en_i && !ready_i && (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && !ready_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/memory/writeback phase sequencer with single-step,
// HALT handling, memory-wait watchdog and retired-instruction counter.
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        step_mode,
   input  logic        step,
   input  logic        halt_ins,
   input  logic        mem_r_req,
   input  logic        mem_w_req,
   input  logic        reg_w_req,
   input  logic [2:0]  stack_op,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   output logic        ir_load,
   output logic        alu_en,
   output logic        mem_r,
   output logic        mem_w,
   output logic        reg_w,
   output logic        sp_update,
   output logic        pc_update,
   output logic [2:0]  state,
   output logic        busy,
   output logic        halted,
   output logic        mem_err,
   output logic [31:0] instr_count
);

   localparam int unsigned TMO_W = tmo_cnt_width(MEM_TIMEOUT);

   state_e      state_q, state_d;
   logic [31:0] instr_cnt_q, instr_cnt_d;
   logic        tmr_clear, tmr_en, tmr_ready, tmr_expired;

   mem_wait_timer #(
      .TIMEOUT (MEM_TIMEOUT),
      .CNT_W   (TMO_W)
   ) u_wait_timer (
      .clk       (clk),
      .rst_n     (rst),
      .clear_i   (tmr_clear),
      .en_i      (tmr_en),
      .ready_i   (tmr_ready),
      .expired_o (tmr_expired)
   );

   assign tmr_en    = (state_q == S_FETCH) || (state_q == S_MEM);
   assign tmr_ready = (state_q == S_FETCH) ? imem_ready : dmem_ready;
   assign tmr_clear = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));

   // Next-state and strobe decode; strobes depend only on state_q and live inputs.
   always_comb begin
      state_d   = state_q;
      ir_load   = 1'b0;
      alu_en    = 1'b0;
      mem_r     = 1'b0;
      mem_w     = 1'b0;
      reg_w     = 1'b0;
      sp_update = 1'b0;
      pc_update = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start || (step_mode && step)) state_d = S_FETCH;
         end
         S_FETCH: begin
            if (imem_ready) begin
               ir_load = 1'b1;
               state_d = S_DECODE;
            end else if (tmr_expired) begin
               state_d = S_ERROR;
            end
         end
         S_DECODE: begin
            state_d = halt_ins ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            alu_en  = 1'b1;
            state_d = (mem_r_req || mem_w_req || (stack_op != STACK_NONE)) ? S_MEM : S_WB;
         end
         S_MEM: begin
            mem_r = mem_r_req;
            mem_w = mem_w_req;
            if (dmem_ready) begin
               state_d = S_WB;
            end else if (tmr_expired) begin
               state_d = S_ERROR;
            end
         end
         S_WB: begin
            reg_w     = reg_w_req;
            sp_update = (stack_op != STACK_NONE);
            pc_update = 1'b1;
            state_d   = step_mode ? S_IDLE : S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         S_ERROR: state_d = S_ERROR;
      endcase
   end

   assign instr_cnt_d = instr_cnt_q + ((state_q == S_WB) ? 32'd1 : 32'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         instr_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign state       = 3'(state_q);
   assign busy        = (state_q >= S_FETCH) && (state_q <= S_WB);
   assign halted      = (state_q == S_HALT);
   assign mem_err     = (state_q == S_ERROR);
   assign instr_count = instr_cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench: each instruction description expands into an expected
// per-cycle trace that is compared against the sequencer on every cycle.
module tb_cpu_sequencer;
   import cpu_seq_pkg::*;

   localparam int unsigned TMO = 15;
   localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3;
   localparam int ST_MEM = 4, ST_WB = 5, ST_HALT = 6, ST_ERROR = 7;

   logic        clk, rst, start, step_mode, step, halt_ins;
   logic        mem_r_req, mem_w_req, reg_w_req, imem_ready, dmem_ready;
   logic [2:0]  stack_op;
   logic        ir_load, alu_en, mem_r, mem_w, reg_w, sp_update, pc_update;
   logic        busy, halted, mem_err;
   logic [2:0]  state;
   logic [31:0] instr_count;

   cpu_sequencer #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
      .halt_ins(halt_ins), .mem_r_req(mem_r_req), .mem_w_req(mem_w_req),
      .reg_w_req(reg_w_req), .stack_op(stack_op), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .ir_load(ir_load), .alu_en(alu_en), .mem_r(mem_r),
      .mem_w(mem_w), .reg_w(reg_w), .sp_update(sp_update), .pc_update(pc_update),
      .state(state), .busy(busy), .halted(halted), .mem_err(mem_err),
      .instr_count(instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit        i_start, i_step, i_sm, i_halt, i_mrq, i_mwq, i_rwq, i_imr, i_dmr;
      bit [2:0]  i_sop;
      int        st;
      bit        ir, alu, mr, mw, rw, spu, pcu;
      int unsigned cnt;
   } cyc_t;

   cyc_t q[$];
   cyc_t cur;
   bit   exp_valid, lit_valid;
   int   errors, checks;
   int   n_mr, n_pcu, n_busy;
   int unsigned lit_cnt;
   int   lit_st, lit_nmr, lit_npcu, lit_nbusy;
   int unsigned m_count;
   bit   a_mrq, a_mwq, a_rwq, a_sm, a_halt;
   bit [2:0] a_sop;

   function automatic void chk(string nm, int unsigned act, int unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endfunction

   function automatic void set_attr(bit mrq, bit mwq, bit rwq, bit [2:0] sop, bit sm, bit hlt);
      a_mrq = mrq; a_mwq = mwq; a_rwq = rwq; a_sop = sop; a_sm = sm; a_halt = hlt;
   endfunction

   function automatic void push(int st, bit imr, bit dmr, bit st_in, bit stp,
                                bit ir, bit alu, bit mr, bit mw, bit rw, bit spu, bit pcu);
      cyc_t c;
      c.i_start = st_in; c.i_step = stp; c.i_sm = a_sm; c.i_halt = a_halt;
      c.i_mrq = a_mrq; c.i_mwq = a_mwq; c.i_rwq = a_rwq; c.i_sop = a_sop;
      c.i_imr = imr; c.i_dmr = dmr; c.st = st;
      c.ir = ir; c.alu = alu; c.mr = mr; c.mw = mw; c.rw = rw; c.spu = spu; c.pcu = pcu;
      c.cnt = m_count;
      q.push_back(c);
   endfunction

   function automatic void push_idle();
      push(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   // launch: 0 none, 1 start pulse, 2 step pulse; fto/mto stop the trace at the timeout.
   function automatic void add_instr(int fw, int mwaits, int launch, bit fto, bit mto);
      if (launch == 1) push(ST_IDLE, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      if (launch == 2) push(ST_IDLE, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      if (fto) begin
         for (int i = 0; i < int'(TMO); i++) push(ST_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         return;
      end
      for (int i = 0; i < fw; i++) push(ST_FETCH, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      push(ST_FETCH, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      push(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (a_halt) return;
      push(ST_EXEC, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      if (a_mrq || a_mwq || a_sop != 3'b000) begin
         if (mto) begin
            for (int i = 0; i < int'(TMO); i++)
               push(ST_MEM, 0, 0, 0, 0, 0, 0, a_mrq, a_mwq, 0, 0, 0);
            return;
         end
         for (int i = 0; i < mwaits; i++) push(ST_MEM, 0, 0, 0, 0, 0, 0, a_mrq, a_mwq, 0, 0, 0);
         push(ST_MEM, 0, 1, 0, 0, 0, 0, a_mrq, a_mwq, 0, 0, 0);
      end
      push(ST_WB, 0, 0, 0, 0, 0, 0, 0, 0, a_rwq, a_sop != 3'b000, 1);
      m_count++;
   endfunction

   task automatic run();
      cyc_t r;
      while (q.size() > 0) begin
         r = q.pop_front();
         @(posedge clk); #1;
         start = r.i_start; step = r.i_step; step_mode = r.i_sm; halt_ins = r.i_halt;
         mem_r_req = r.i_mrq; mem_w_req = r.i_mwq; reg_w_req = r.i_rwq;
         stack_op = r.i_sop; imem_ready = r.i_imr; dmem_ready = r.i_dmr;
         cur = r;
         exp_valid = 1'b1;
      end
      @(negedge clk); #1;
      exp_valid = 1'b0;
   endtask

   task automatic do_reset();
      exp_valid = 1'b0;
      start = 0; step = 0; step_mode = 0; halt_ins = 0; mem_r_req = 0; mem_w_req = 0;
      reg_w_req = 0; stack_op = 3'b000; imem_ready = 0; dmem_ready = 0;
      set_attr(0, 0, 0, 3'b000, 0, 0);
      m_count = 0;
      rst = 1'b0;
      @(negedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic lit(int unsigned cnt, int st, int nmr, int npcu, int nbusy);
      lit_cnt = cnt; lit_st = st; lit_nmr = nmr; lit_npcu = npcu; lit_nbusy = nbusy;
      lit_valid = 1'b1;
      @(negedge clk); #1;
      lit_valid = 1'b0;
   endtask

   // Single compare process: reset values, per-cycle trace, and end-of-test literals.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            n_mr = 0; n_pcu = 0; n_busy = 0;
            chk("rst_state", 32'(state), 0);
            chk("rst_outputs", 32'({ir_load, alu_en, mem_r, mem_w, reg_w, sp_update,
                                     pc_update, busy, halted, mem_err}), 0);
            chk("rst_count", instr_count, 0);
         end else begin
            if (mem_r) n_mr++;
            if (pc_update) n_pcu++;
            if (busy) n_busy++;
            if (exp_valid) begin
               chk("state", 32'(state), 32'(cur.st));
               chk("ir_load", 32'(ir_load), 32'(cur.ir));
               chk("alu_en", 32'(alu_en), 32'(cur.alu));
               chk("mem_r", 32'(mem_r), 32'(cur.mr));
               chk("mem_w", 32'(mem_w), 32'(cur.mw));
               chk("reg_w", 32'(reg_w), 32'(cur.rw));
               chk("sp_update", 32'(sp_update), 32'(cur.spu));
               chk("pc_update", 32'(pc_update), 32'(cur.pcu));
               chk("busy", 32'(busy), 32'(cur.st >= ST_FETCH && cur.st <= ST_WB));
               chk("halted", 32'(halted), 32'(cur.st == ST_HALT));
               chk("mem_err", 32'(mem_err), 32'(cur.st == ST_ERROR));
               chk("instr_count", instr_count, cur.cnt);
            end
            if (lit_valid) begin
               chk("lit_count", instr_count, lit_cnt);
               chk("lit_state", 32'(state), 32'(lit_st));
               chk("lit_mem_r_cycles", 32'(n_mr), 32'(lit_nmr));
               chk("lit_pc_pulses", 32'(n_pcu), 32'(lit_npcu));
               chk("lit_busy_cycles", 32'(n_busy), 32'(lit_nbusy));
            end
         end
      end
   end

   initial begin
      int base;
      errors = 0; checks = 0; lit_valid = 0;
      do_reset();

      // ALU op twice; second in step mode so it parks in IDLE: states 0,1,2,3,5,1,...
      set_attr(0, 0, 1, STACK_NONE, 0, 0);
      add_instr(0, 0, 1, 0, 0);
      a_sm = 1;
      add_instr(0, 0, 0, 0, 0);
      push_idle();
      run();
      lit(2, ST_IDLE, 0, 2, 8);

      // Load with three dmem wait cycles: mem_r held 4 cycles, 8 busy cycles.
      do_reset();
      set_attr(1, 0, 1, STACK_NONE, 1, 0);
      add_instr(0, 3, 1, 0, 0);
      push_idle();
      run();
      lit(1, ST_IDLE, 4, 1, 8);

      // CALL then POP; step_mode raised for the POP takes effect at its WB.
      do_reset();
      set_attr(0, 1, 0, STACK_CALL, 0, 0);
      add_instr(0, 1, 1, 0, 0);
      set_attr(1, 0, 1, STACK_POP, 1, 0);
      add_instr(2, 0, 0, 0, 0);
      push_idle();
      push_idle();
      run();
      lit(2, ST_IDLE, 1, 2, 13);

      // Step mode: three step pulses 10 cycles apart (ALU, PUSH, RET).
      do_reset();
      for (int k = 0; k < 3; k++) begin
         if (k == 0) set_attr(0, 0, 1, STACK_NONE, 1, 0);
         if (k == 1) set_attr(0, 1, 0, STACK_PUSH, 1, 0);
         if (k == 2) set_attr(1, 0, 0, STACK_RET, 1, 0);
         base = q.size();
         add_instr(0, 0, 2, 0, 0);
         while (q.size() - base < 10) push_idle();
      end
      run();
      lit(3, ST_IDLE, 1, 3, 14);

      // Fetch never ready: ERROR after 15 not-ready cycles.
      do_reset();
      set_attr(0, 0, 1, STACK_NONE, 0, 0);
      add_instr(0, 0, 1, 1, 0);
      for (int i = 0; i < 3; i++) push(ST_ERROR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run();
      lit(0, ST_ERROR, 0, 0, 15);

      // Fetch ready on the 15th cycle: ready wins over the timeout.
      do_reset();
      set_attr(0, 0, 1, STACK_NONE, 1, 0);
      add_instr(14, 0, 1, 0, 0);
      push_idle();
      run();
      lit(1, ST_IDLE, 0, 1, 18);

      // Data memory never ready: ERROR after 15 MEM cycles with mem_r held.
      do_reset();
      set_attr(1, 0, 1, STACK_NONE, 0, 0);
      add_instr(0, 0, 1, 0, 1);
      for (int i = 0; i < 3; i++) push(ST_ERROR, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      run();
      lit(0, ST_ERROR, 15, 0, 18);

      // HALT decoded: absorbing even with start held.
      do_reset();
      set_attr(0, 0, 1, STACK_NONE, 0, 1);
      add_instr(0, 0, 1, 0, 0);
      for (int i = 0; i < 8; i++) push(ST_HALT, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      run();
      lit(0, ST_HALT, 0, 0, 2);

      // Reset asserted mid-MEM: strobes drop before the next edge.
      do_reset();
      set_attr(1, 0, 1, STACK_NONE, 0, 0);
      push(ST_IDLE, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      push(ST_FETCH, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      push(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      push(ST_EXEC, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) push(ST_MEM, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      run();
      @(posedge clk); #2;
      rst = 1'b0;
      @(negedge clk); #1;
      rst = 1'b1;
      @(negedge clk); #1;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
